// File: rtl/alu_ctrl_if.sv
// Decoder-to-execute handshake bundle for the ALU control unit.
// The slave side is the ALU control block; the master side drives decode ops and consumes selects.
interface alu_ctrl_if #(
    parameter int OP_W    = 3,
    parameter int FUNCT_W = 4,
    parameter int SEL_W   = 4,
    parameter int ERR_W   = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [OP_W-1:0]    alu_op;
    logic [FUNCT_W-1:0] funct;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [SEL_W-1:0]   alu_sel;
    logic               multi_cycle;
    logic               illegal;
    logic               busy;
    logic [ERR_W-1:0]   err_count;

    modport master (
        output in_valid, alu_op, funct, flush, out_ready,
        input  in_ready, out_valid, alu_sel, multi_cycle, illegal, busy, err_count
    );

    modport slave (
        input  in_valid, alu_op, funct, flush, out_ready,
        output in_ready, out_valid, alu_sel, multi_cycle, illegal, busy, err_count
    );
endinterface

// File: rtl/alu_ctrl_pipe.sv
// Registered ALU control unit: decodes alu_op/funct into an ALU select, holds it in a
// one-entry valid/ready stage, stalls intake while a MUL runs and counts illegal encodings.
module alu_ctrl_pipe #(
    parameter int OP_W       = 3,
    parameter int FUNCT_W    = 4,
    parameter int SEL_W      = 4,
    parameter int MUL_CYCLES = 4,
    parameter int ERR_W      = 8
) (
    input logic       clk,
    input logic       rst,
    alu_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(MUL_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        HOLD    = 2'b01,
        MC_WAIT = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   alu_sel_q, alu_sel_d;
    logic               multi_cycle_q, multi_cycle_d;
    logic               illegal_q, illegal_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
    logic               in_ready_s, accept_s;
    logic               op_hi_bad_s, fn_hi_bad_s, hi_bad_s;
    logic [5:0]         dec_s;

    // Result packed as {illegal, multi_cycle, sel[3:0]}; any nonzero upper field bit forces illegal.
    function automatic logic [5:0] decode_op(input logic [2:0] op, input logic [3:0] fn,
                                             input logic hi_bad);
        logic [5:0] r;
        r = {2'b00, 4'b0000};
        case (op)
            3'b000: r = {2'b00, 4'b0000};
            3'b001: r = {2'b00, 4'b0001};
            3'b010: begin
                case (fn)
                    4'b0000, 4'b0001, 4'b0010, 4'b0011,
                    4'b0100, 4'b0101, 4'b0110, 4'b0111,
                    4'b1001: r = {2'b00, fn};
                    4'b1000: r = {2'b01, 4'b1000};
                    default: r = {2'b10, 4'b1111};
                endcase
            end
            3'b011: r = {2'b00, 4'b0010};
            3'b100: r = {2'b00, 4'b0011};
            3'b101: r = {2'b00, 4'b1001};
            3'b110: r = {2'b00, 4'b1010};
            default: r = {2'b10, 4'b1111};
        endcase
        return hi_bad ? {2'b10, 4'b1111} : r;
    endfunction

    generate
        if (OP_W > 3) begin : g_op_hi
            assign op_hi_bad_s = |bus.alu_op[OP_W-1:3];
        end else begin : g_op_nohi
            assign op_hi_bad_s = 1'b0;
        end
        if (FUNCT_W > 4) begin : g_fn_hi
            assign fn_hi_bad_s = |bus.funct[FUNCT_W-1:4];
        end else begin : g_fn_nohi
            assign fn_hi_bad_s = 1'b0;
        end
    endgenerate

    // Decode of the offered op; funct upper bits only matter for R-type.
    always_comb begin
        hi_bad_s = op_hi_bad_s | (fn_hi_bad_s & (bus.alu_op[2:0] == 3'b010));
        dec_s    = decode_op(bus.alu_op[2:0], bus.funct[3:0], hi_bad_s);
    end

    // Next-state, intake handshake and held-op update.
    always_comb begin
        state_d       = state_q;
        alu_sel_d     = alu_sel_q;
        multi_cycle_d = multi_cycle_q;
        illegal_d     = illegal_q;
        cnt_d         = cnt_q;
        err_count_d   = err_count_q;
        in_ready_s    = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready_s = ~bus.flush;
            end
            HOLD: begin
                // flush wins over out_ready, so a flushed MUL never launches
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (bus.out_ready) begin
                    if (multi_cycle_q) begin
                        state_d = MC_WAIT;
                        cnt_d   = CNT_W'(MUL_CYCLES - 1);
                    end else begin
                        state_d    = IDLE;
                        in_ready_s = 1'b1;
                    end
                end else begin
                    state_d = HOLD;
                end
            end
            MC_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                end else begin
                    state_d = MC_WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        accept_s = bus.in_valid & in_ready_s;
        if (accept_s) begin
            state_d       = HOLD;
            alu_sel_d     = dec_s[5] ? {SEL_W{1'b1}} : SEL_W'(dec_s[3:0]);
            multi_cycle_d = dec_s[4];
            illegal_d     = dec_s[5];
            if (dec_s[5] && (err_count_q != {ERR_W{1'b1}})) begin
                err_count_d = err_count_q + ERR_W'(1);
            end else begin
                err_count_d = err_count_q;
            end
        end else begin
            alu_sel_d = alu_sel_d;
        end

        out_valid_d = (state_d == HOLD);
        busy_d      = (state_d == MC_WAIT);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            alu_sel_q     <= {SEL_W{1'b0}};
            multi_cycle_q <= 1'b0;
            illegal_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            cnt_q         <= {CNT_W{1'b0}};
            err_count_q   <= {ERR_W{1'b0}};
        end else begin
            state_q       <= state_d;
            alu_sel_q     <= alu_sel_d;
            multi_cycle_q <= multi_cycle_d;
            illegal_q     <= illegal_d;
            out_valid_q   <= out_valid_d;
            busy_q        <= busy_d;
            cnt_q         <= cnt_d;
            err_count_q   <= err_count_d;
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_q;
    assign bus.alu_sel     = alu_sel_q;
    assign bus.multi_cycle = multi_cycle_q;
    assign bus.illegal     = illegal_q;
    assign bus.busy        = busy_q;
    assign bus.err_count   = err_count_q;
endmodule
